// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder.
//   byte_t / addr_t      : data byte and request address types
//   READ_SIGNAL/WRITE_SIGNAL : encodings of the cache r_nw pin
//   IO_DATA_ADDR / IO_CTRL_ADDR : IO register addresses
package mem_responder_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] addr_t;

  localparam logic READ_SIGNAL  = 1'b1;
  localparam logic WRITE_SIGNAL = 1'b0;

  localparam addr_t IO_DATA_ADDR = 32'h0003_0000;
  localparam addr_t IO_CTRL_ADDR = 32'h0003_0004;

  // Bits [17:16] == 2'b11 select the IO window; everything else is RAM.
  function automatic logic is_io_addr(input addr_t addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Cache memory port plus host byte link, grouped as one bundle.
//   master : cache + host side (drives requests, tx_ready, rx push)
//   slave  : responder side (drives read data, TX head, io_full)
interface mem_responder_if;
  import mem_responder_pkg::*;

  addr_t mem_addr;
  logic  mem_r_nw;
  byte_t mem_din;
  byte_t mem_dout;
  logic  io_full;
  logic  tx_valid;
  byte_t tx_data;
  logic  tx_ready;
  logic  rx_valid;
  byte_t rx_data;

  modport master (
    output mem_addr, mem_r_nw, mem_din, tx_ready, rx_valid, rx_data,
    input  mem_dout, io_full, tx_valid, tx_data
  );

  modport slave (
    input  mem_addr, mem_r_nw, mem_din, tx_ready, rx_valid, rx_data,
    output mem_dout, io_full, tx_valid, tx_data
  );

endinterface

// File: rtl/mem_responder_byte_fifo.sv
// Byte FIFO with 2**FIFO_AW entries.
//   clk, rst_n       : clock, async active-low reset
//   push_i / wdata_i : write request and data (dropped when full unless popping)
//   pop_i            : read request (ignored when empty)
//   head_o           : oldest entry, 0 when empty
//   count_o          : occupancy, FIFO_AW+1 bits
//   full_o / empty_o : occupancy flags
module byte_fifo
  import mem_responder_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  byte_t            wdata_i,
  input  logic             pop_i,
  output byte_t            head_o,
  output logic [FIFO_AW:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;

  byte_t              mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = count_q == CntW'(Depth);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the cache memory port: single-byte RAM plus an IO
// window holding a TX FIFO, an RX FIFO, a status register and a halt register.
//   clk, rst_n    : clock, async active-low reset
//   rdy_i         : global enable, 0 freezes all state
//   bus           : cache request/response and host byte link (slave side)
//   halt_o        : sticky halt flag
//   tx_overflow_o : sticky, a TX byte was dropped
//   rx_overflow_o : sticky, an RX byte was dropped
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned RAM_AW  = 17,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy_i,
  mem_responder_if.slave bus,
  output logic           halt_o,
  output logic           tx_overflow_o,
  output logic           rx_overflow_o
);

  localparam int unsigned FifoDepth = 2 ** FIFO_AW;
  localparam int unsigned CntW      = FIFO_AW + 1;

  byte_t ram_q [2 ** RAM_AW];

  byte_t            mem_dout_q, mem_dout_d;
  logic             halt_q, halt_d, tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic             is_io, is_data, is_ctrl, rd_en, wr_en;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [FIFO_AW:0] tx_count, rx_count;
  byte_t            tx_head, rx_head;

  always_comb begin
    is_io   = is_io_addr(bus.mem_addr);
    is_data = is_io && (bus.mem_addr == IO_DATA_ADDR);
    is_ctrl = is_io && (bus.mem_addr == IO_CTRL_ADDR);
    rd_en   = rdy_i && (bus.mem_r_nw == READ_SIGNAL);
    wr_en   = rdy_i && (bus.mem_r_nw == WRITE_SIGNAL);
    tx_push = wr_en && is_data;
    tx_pop  = rdy_i && !tx_empty && bus.tx_ready;
    rx_push = rdy_i && bus.rx_valid;
    rx_pop  = rd_en && is_data && !rx_empty;
  end

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .wdata_i (bus.mem_din),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .wdata_i (bus.rx_data),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_comb begin
    mem_dout_d = mem_dout_q;
    halt_d     = halt_q;
    tx_ovf_d   = tx_ovf_q;
    rx_ovf_d   = rx_ovf_q;
    if (rd_en) begin
      if (!is_io)       mem_dout_d = ram_q[bus.mem_addr[RAM_AW-1:0]];
      else if (is_data) mem_dout_d = rx_head;  // head reads 0 when empty
      else if (is_ctrl) mem_dout_d = {6'b0, rx_count != '0, tx_full};
      else              mem_dout_d = '0;
    end
    if (wr_en && is_ctrl) halt_d = 1'b1;
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push && rx_full && !rx_pop) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dout_q <= '0;
      halt_q     <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      mem_dout_q <= mem_dout_d;
      halt_q     <= halt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !is_io) ram_q[bus.mem_addr[RAM_AW-1:0]] <= bus.mem_din;
  end

  assign bus.mem_dout = mem_dout_q;
  assign bus.io_full  = tx_count >= CntW'(FifoDepth - 2);
  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_head;
  assign halt_o        = halt_q;
  assign tx_overflow_o = tx_ovf_q;
  assign rx_overflow_o = rx_ovf_q;

endmodule
